// File: rtl/qoi_stream_framer_if.sv
// qoi_stream_framer_if
// Byte-stream handshake bundle for the QOI framer.
//   in_data/in_valid/in_last/in_ready : encoded chunk bytes from the upstream encoder
//   out_data/out_valid/out_ready      : framed QOI file bytes to the downstream sink
// Modports:
//   slave  : framer view (consumes the input stream, produces the output stream)
//   master : environment view (produces input bytes, sinks output bytes)
interface qoi_stream_framer_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_last;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;

   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, out_data, out_valid
   );

   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, out_data, out_valid
   );
endinterface

// File: rtl/qoi_stream_framer.sv
// qoi_stream_framer
// Wraps a stream of QOI-encoded chunk bytes into a complete QOI file:
// 14-byte header (magic, width, height, channels, colorspace), the body
// bytes, then the 8-byte end marker (seven 00, one 01).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : pulse in IDLE begins a frame, samples the fields below
//   width, height       : image dimensions, emitted big-endian
//   channels, colorspace: single-byte header fields
//   bus (slave)         : input/output byte streams, valid/ready handshake
//   busy                : frame in progress (any state but IDLE)
//   done                : one-cycle pulse after the last trailer byte transfers
//   byte_count          : output transfers this frame
// Build option: define QOI_FRAMER_COUNT_EN to implement byte_count;
// otherwise it is tied to zero.
//
// state   | meaning
// IDLE    | waiting for start
// HEADER  | emitting header bytes 0..13
// BODY    | forwarding input bytes, latency 1
// TRAILER | emitting the 8-byte end marker
// DONE    | done pulse, return to IDLE
module qoi_stream_framer #(
   parameter logic [31:0] MAGIC = 32'h716F6966
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] width,
   input  logic [31:0] height,
   input  logic [7:0]  channels,
   input  logic [7:0]  colorspace,
   qoi_stream_framer_if.slave bus,
   output logic        busy,
   output logic        done,
   output logic [31:0] byte_count
);

   typedef enum logic [2:0] {S_IDLE, S_HEADER, S_BODY, S_TRAILER, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [4:0]  idx_q, idx_d;
   logic [7:0]  out_data_q, out_data_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] width_q, width_d, height_q, height_d;
   logic [7:0]  channels_q, channels_d, colorspace_q, colorspace_d;
   logic [7:0]  hdr_byte;
   logic        slot_free;
   logic        in_acc;

   // Output register can take a new byte when empty or being drained.
   assign slot_free = !out_valid_q || bus.out_ready;
   assign in_acc    = bus.in_ready && bus.in_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         width_q      <= '0;
         height_q     <= '0;
         channels_q   <= '0;
         colorspace_q <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         width_q      <= width_d;
         height_q     <= height_d;
         channels_q   <= channels_d;
         colorspace_q <= colorspace_d;
      end
   end

   // BODY is entered as soon as the last header byte is loaded, so the first
   // body byte can be accepted in the same cycle that header byte drains.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (start) state_d = S_HEADER;
         S_HEADER:  if (slot_free && idx_q == 5'd13) state_d = S_BODY;
         S_BODY:    if (in_acc && bus.in_last) state_d = S_TRAILER;
         S_TRAILER: if (idx_q == 5'd8 && out_valid_q && bus.out_ready) state_d = S_DONE;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      case (idx_q)
         5'd0:    hdr_byte = MAGIC[31:24];
         5'd1:    hdr_byte = MAGIC[23:16];
         5'd2:    hdr_byte = MAGIC[15:8];
         5'd3:    hdr_byte = MAGIC[7:0];
         5'd4:    hdr_byte = width_q[31:24];
         5'd5:    hdr_byte = width_q[23:16];
         5'd6:    hdr_byte = width_q[15:8];
         5'd7:    hdr_byte = width_q[7:0];
         5'd8:    hdr_byte = height_q[31:24];
         5'd9:    hdr_byte = height_q[23:16];
         5'd10:   hdr_byte = height_q[15:8];
         5'd11:   hdr_byte = height_q[7:0];
         5'd12:   hdr_byte = channels_q;
         5'd13:   hdr_byte = colorspace_q;
         default: hdr_byte = 8'h00;
      endcase
   end

   // idx counts bytes already loaded into the output register for the
   // current header or trailer section.
   always_comb begin
      idx_d        = idx_q;
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      width_d      = width_q;
      height_d     = height_q;
      channels_d   = channels_q;
      colorspace_d = colorspace_q;
      bus.in_ready = 1'b0;
      busy         = (state_q != S_IDLE);
      done         = (state_q == S_DONE);
      case (state_q)
         S_IDLE: begin
            out_valid_d = 1'b0;
            if (start) begin
               width_d      = width;
               height_d     = height;
               channels_d   = channels;
               colorspace_d = colorspace;
               // Counter clears; magic byte 0 is preloaded immediately.
               out_data_d   = MAGIC[31:24];
               out_valid_d  = 1'b1;
               idx_d        = 5'd1;
            end
         end
         S_HEADER: begin
            if (slot_free) begin
               out_data_d  = hdr_byte;
               out_valid_d = 1'b1;
               idx_d       = (idx_q == 5'd13) ? 5'd0 : idx_q + 5'd1;
            end
         end
         S_BODY: begin
            bus.in_ready = slot_free;
            if (in_acc) begin
               out_data_d  = bus.in_data;
               out_valid_d = 1'b1;
               if (bus.in_last) idx_d = 5'd0;
            end else if (bus.out_ready) begin
               out_valid_d = 1'b0;
            end
         end
         S_TRAILER: begin
            if (idx_q < 5'd8) begin
               if (slot_free) begin
                  out_data_d  = (idx_q == 5'd7) ? 8'h01 : 8'h00;
                  out_valid_d = 1'b1;
                  idx_d       = idx_q + 5'd1;
               end
            end else if (bus.out_ready) begin
               out_valid_d = 1'b0;
               idx_d       = 5'd0;
            end
         end
         S_DONE: begin
            out_valid_d = 1'b0;
         end
         default: begin
            out_valid_d = 1'b0;
         end
      endcase
   end

   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;

`ifdef QOI_FRAMER_COUNT_EN
   logic [31:0] byte_count_q, byte_count_d;

   always_comb begin
      byte_count_d = byte_count_q;
      if (state_q == S_IDLE && start)
         byte_count_d = '0;
      else if (out_valid_q && bus.out_ready)
         byte_count_d = byte_count_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) byte_count_q <= '0;
      else     byte_count_q <= byte_count_d;
   end

   assign byte_count = byte_count_q;
`else
   assign byte_count = 32'h0;
`endif

endmodule
